// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame/parity bit constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Per-bit edge counter with a 3-sample majority vote around mid-bit.
// While disabled the counter sits at 1, so the first enabled cycle is count 1.
module uart_rx_bit_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      serial_in,
    output logic                      sampled_bit,
    output logic                      sample_valid,
    output logic                      bit_done
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic                      r_s0;
    logic                      r_s1;
    logic [PRESCALE_WIDTH-1:0] w_half;

    assign w_half = prescale >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_s0  <= 1'b1;
            r_s1  <= 1'b1;
        end else if (!enable) begin
            // The detection cycle (FSM still idle) is count 0.
            r_cnt <= ONE;
        end else begin
            r_cnt <= bit_done ? '0 : r_cnt + ONE;
            if (r_cnt == w_half - ONE) r_s0 <= serial_in;
            if (r_cnt == w_half)       r_s1 <= serial_in;
        end
    end

    assign sample_valid = enable && (r_cnt == w_half + ONE);
    assign bit_done     = enable && (r_cnt == prescale - ONE);
    assign sampled_bit  = (r_s0 & r_s1) | (r_s0 & serial_in) | (r_s1 & serial_in);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks.
// Results appear as one-cycle pulses exactly N*P cycles after start detection.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      serial_data_in,
    output logic [DATA_WIDTH-1:0]     parallel_data,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      stop_error,
    output logic                      busy
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic [1:0]                r_sync;
    logic [1:0]                r_fill;
    logic                      r_armed;
    uart_state_e               r_state;
    uart_state_e               w_next;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_par_en;
    logic                      r_par_type;
    logic [BCW-1:0]            r_bitcnt;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_par_bad;
    logic                      r_stop_bit;

    logic w_start_det;
    logic w_sampled_bit;
    logic w_sample_valid;
    logic w_bit_done;
    logic w_exp_par;

    uart_rx_bit_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .enable       (busy),
        .prescale     (r_prescale),
        .serial_in    (r_sync[1]),
        .sampled_bit  (w_sampled_bit),
        .sample_valid (w_sample_valid),
        .bit_done     (w_bit_done)
    );

    assign busy        = (r_state != ST_IDLE);
    assign w_start_det = (r_state == ST_IDLE) && r_armed && !r_sync[1];
    assign w_exp_par   = (^r_shift) ^ (r_par_type == PARITY_ODD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_det) w_next = ST_START;
            ST_START: begin
                if (w_sample_valid && w_sampled_bit != START_BIT) w_next = ST_IDLE;
                else if (w_bit_done)                             w_next = ST_DATA;
            end
            ST_DATA:   if (w_bit_done && r_bitcnt == LAST_BIT)
                           w_next = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_bit_done) w_next = ST_STOP;
            ST_STOP:   if (w_bit_done) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync        <= 2'b11;
            r_fill        <= 2'b00;
            r_armed       <= 1'b0;
            r_prescale    <= '0;
            r_par_en      <= 1'b0;
            r_par_type    <= PARITY_EVEN;
            r_bitcnt      <= '0;
            r_shift       <= '0;
            r_par_bad     <= 1'b0;
            r_stop_bit    <= STOP_BIT;
            parallel_data <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            stop_error    <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], serial_data_in};
            r_fill       <= {r_fill[0], 1'b1};
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            // Ignore the synchronizer's reset value: arm only on a real high line.
            if (r_fill[1] && r_sync[1]) r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_start_det) begin
                    r_prescale <= prescale;
                    r_par_en   <= parity_enable;
                    r_par_type <= parity_type;
                    r_bitcnt   <= '0;
                    r_par_bad  <= 1'b0;
                end
                ST_DATA: begin
                    if (w_sample_valid) r_shift  <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                    if (w_bit_done)     r_bitcnt <= r_bitcnt + BCW'(1);
                end
                ST_PARITY: if (w_sample_valid) r_par_bad <= (w_sampled_bit != w_exp_par);
                ST_STOP: begin
                    if (w_sample_valid) r_stop_bit <= w_sampled_bit;
                    if (w_bit_done) begin
                        stop_error   <= (r_stop_bit != STOP_BIT);
                        parity_error <= r_par_bad;
                        if (r_stop_bit == STOP_BIT && !r_par_bad) begin
                            parallel_data <= r_shift;
                            data_valid    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized scoreboard bench for uart_receiver: frames are built bit by bit
// from the frame format, expected outcomes and pulse cycles queued per frame.
module tb_uart_receiver;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          parity_enable = 1'b0;
    logic          parity_type = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic          serial_data_in = 1'b1;
    logic [DW-1:0] parallel_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          busy;

    uart_receiver #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk            (clk),
        .reset          (reset),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type),
        .prescale       (prescale),
        .serial_data_in (serial_data_in),
        .parallel_data  (parallel_data),
        .data_valid     (data_valid),
        .parity_error   (parity_error),
        .stop_error     (stop_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          dv;
        bit          pe;
        bit          se;
        logic [7:0]  data;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame starting now; queue the outcome the frame format implies.
    task automatic send(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                        input bit bad_par, input bit stop_v);
        exp_t e;
        bit   pbit;
        int   n;
        pbit = (^d) ^ ptyp ^ bad_par;
        n    = pen ? 11 : 10;
        prescale      = PW'(p);
        parity_enable = pen;
        parity_type   = ptyp;
        e.at   = cyc + 2 + n * p;
        e.se   = !stop_v;
        e.pe   = pen && bad_par;
        e.dv   = stop_v && !(pen && bad_par);
        e.data = d;
        sbq.push_back(e);
        serial_data_in = 1'b0;
        step(p);
        parity_enable = 1'($urandom);
        parity_type   = 1'($urandom);
        prescale      = PW'(2 * $urandom_range(3, 31));
        for (int i = 0; i < 8; i++) begin
            serial_data_in = d[i];
            step(p);
        end
        if (pen) begin
            serial_data_in = pbit;
            step(p);
        end
        serial_data_in = stop_v;
        step(p);
        serial_data_in = 1'b1;
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (data_valid || parity_error || stop_error)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b at cycle %0d, expected none",
                             data_valid, parity_error, stop_error, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_cycle", cyc, e.at);
                    chk("pulse_flags", {data_valid, parity_error, stop_error}, {e.dv, e.pe, e.se});
                    if (e.dv) last_good = e.data;
                    chk("parallel_data", parallel_data, last_good);
                end
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  k;
        bit  seen_busy;
        int  p;
        int  waited;
        bit  pen;

        step(3);
        @(negedge clk);
        chk("rst_parallel_data", parallel_data, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_parity_error", parity_error, 0);
        chk("rst_stop_error", stop_error, 0);
        chk("rst_busy", busy, 0);
        step(1);
        reset = 1'b1;
        step(10);

        // Directed frames
        send(8'hE6, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        step(5);
        send(8'hFF, 8, 1'b1, 1'b1, 1'b1, 1'b1);
        step(5);
        send(8'hF4, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        step(5);
        send(8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5);

        // Three-cycle glitch: busy for counts 1..9, idle again at count 10
        prescale = 6'd16;
        k = cyc;
        serial_data_in = 1'b0;
        step(3);
        serial_data_in = 1'b1;
        @(negedge clk);
        chk("glitch_busy_on", busy, 1);
        while (cyc < k + 11) @(negedge clk);
        chk("glitch_busy_cnt9", busy, 1);
        @(negedge clk);
        chk("glitch_busy_cnt10", busy, 0);
        step(5);
        send(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back, no idle gap
        send(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'hA3, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        step(5);

        // Reset mid-DATA, released with the line still low
        prescale = 6'd16;
        parity_enable = 1'b0;
        serial_data_in = 1'b0;
        step(16 + 16 * 3 + 5);
        @(negedge clk);
        chk("mid_frame_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_parallel_data", parallel_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulses", {data_valid, parity_error, stop_error}, 0);
        last_good = 8'h00;
        step(3);
        reset = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        chk("low_after_reset_no_busy", seen_busy, 0);
        step(1);
        serial_data_in = 1'b1;
        step(1);
        send(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3);

        // Randomized frames
        for (int i = 0; i < 25; i++) begin
            p   = 2 * $urandom_range(3, 31);
            pen = 1'($urandom);
            send(8'($urandom), p, pen, 1'($urandom),
                 pen && ($urandom_range(0, 3) == 0), $urandom_range(0, 4) != 0);
            step($urandom_range(0, 4));
        end

        waited = 0;
        while (sbq.size() != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
